// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with KMP mismatch fallback
//
// Detects a PAT_LEN-bit PATTERN (MSB received first) on a 1-bit serial stream.
// Overlapping or non-overlapping detection is selected at run time.
// Optional feature macro: MATCH_COUNT_EN adds a saturating match counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; has priority over en
//   en         bit-valid strobe; d is consumed only when en=1
//   d          serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping (sampled at full match)
//   pd         registered one-cycle pattern-detect pulse
//   match_len  number of pattern bits currently matched
//   match_cnt  saturating count of detections (MATCH_COUNT_EN only)
module seq_detect_param #(
   parameter int                 PAT_LEN = 5,
   parameter logic [PAT_LEN-1:0] PATTERN = 5'b00101,
   parameter int                 CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       d,
   input  logic                       overlap,
   output logic                       pd,
   output logic [$clog2(PAT_LEN)-1:0] match_len
`ifdef MATCH_COUNT_EN
   ,
   output logic [CNT_W-1:0]           match_cnt
`endif
);
   localparam int KW = $clog2(PAT_LEN);

   // pattern bit in arrival order: index 0 is the first bit received
   function automatic logic pbit(input int i);
      logic [PAT_LEN-1:0] s;
      s = PATTERN >> (PAT_LEN - 1 - i);
      return s[0];
   endfunction

   // longest proper border: prefix of PATTERN that is also a suffix
   function automatic int border();
      int   b;
      logic ok;
      b = 0;
      for (int j = 1; j < PAT_LEN; j++) begin
         ok = 1'b1;
         for (int t = 0; t < j; t++)
            if (pbit(t) != pbit(PAT_LEN - j + t)) ok = 1'b0;
         if (ok) b = j;
      end
      return b;
   endfunction

   // state after seeing pattern bits 0..k-1 followed by bit b: the longest j<=k
   // whose last j received bits equal the first j pattern bits
   function automatic int fallback(input int k, input logic b);
      int   best;
      int   idx;
      logic ok;
      logic sb;
      best = 0;
      for (int j = 1; j <= k; j++) begin
         ok = 1'b1;
         for (int t = 0; t < j; t++) begin
            idx = k + 1 - j + t;
            sb  = (idx == k) ? b : pbit(idx);
            if (sb != pbit(t)) ok = 1'b0;
         end
         if (ok) best = j;
      end
      return best;
   endfunction

   localparam int B = border();

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_detect_param: PAT_LEN must be in 2..16");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("seq_detect_param: CNT_W must be at least 1");
   end

   logic [PAT_LEN-1:0] w_pat;
   logic [KW-1:0]      w_fb [PAT_LEN];
   logic [KW-1:0]      r_k;
   logic [KW-1:0]      w_nk;
   logic               r_pd;
   logic               w_exp;
   logic               w_last;
   logic               w_full;

   // elaboration-time tables: expected bit and mismatch fallback per state
   for (genvar i = 0; i < PAT_LEN; i++) begin : g_tab
      assign w_pat[i] = pbit(i);
      assign w_fb[i]  = KW'(fallback(i, !pbit(i)));
   end

   assign w_exp  = w_pat[r_k];
   assign w_last = r_k == KW'(PAT_LEN - 1);
   assign w_full = en && d == w_exp && w_last;
   assign w_nk   = !en         ? r_k :
                   d != w_exp  ? w_fb[r_k] :
                   !w_last     ? r_k + 1'b1 :
                   overlap     ? KW'(B) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k  <= '0;
         r_pd <= 1'b0;
      end else begin
         r_k  <= w_nk;
         r_pd <= w_full;
      end
   end

   assign pd        = r_pd;
   assign match_len = r_k;

`ifdef MATCH_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (w_full && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
   end

   assign match_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param across three pattern configurations
module tb_seq_detect_param;
   localparam int          N      = 3;
   localparam int          PL [N] = '{5, 4, 2};
   localparam logic [15:0] PT [N] = '{16'b00101, 16'b1011, 16'b00};

   typedef struct packed {
      logic [N-1:0]      pd;
      logic [N-1:0][3:0] ml;
      logic [N-1:0][1:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        d;
   logic        overlap;
   logic        pd  [N];
   logic [3:0]  ml  [N];
   logic [1:0]  cnt [N];
   logic [15:0] hist [N];
   int          hlen [N];
   int          mcnt [N];
   exp_t        q [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int       L = PL[g];
      localparam logic [L-1:0] P = PT[g][L-1:0];
      logic [$clog2(L)-1:0] w_ml;
      seq_detect_param #(.PAT_LEN(L), .PATTERN(P), .CNT_W(2)) u_dut (
         .clk(clk),
         .rst(rst),
         .en(en),
         .d(d),
         .overlap(overlap),
         .pd(pd[g]),
         .match_len(w_ml)
`ifdef MATCH_COUNT_EN
         ,
         .match_cnt(cnt[g])
`endif
      );
      assign ml[g] = 4'(w_ml);
`ifndef MATCH_COUNT_EN
      assign cnt[g] = '0;
`endif
   end

   function automatic logic [15:0] mask(input int n);
      logic [16:0] m;
      m = (17'd1 << n) - 17'd1;
      return m[15:0];
   endfunction

   // longest suffix of the accepted history (shorter than the pattern) that is a pattern prefix
   function automatic int prefix_len(input int g);
      int best;
      best = 0;
      for (int j = 1; j < PL[g]; j++)
         if (j <= hlen[g] && (hist[g] & mask(j)) == (PT[g] >> (PL[g] - j))) best = j;
      return best;
   endfunction

   task automatic step(input logic r, input logic e, input logic b, input logic ov);
      exp_t x;
      rst = r;
      en = e;
      d = b;
      overlap = ov;
      for (int g = 0; g < N; g++) begin
         logic full;
         full = 1'b0;
         if (r) begin
            hlen[g] = 0;
            mcnt[g] = 0;
         end else if (e) begin
            hist[g] = {hist[g][14:0], b};
            if (hlen[g] < 16) hlen[g]++;
            full = hlen[g] >= PL[g] && (hist[g] & mask(PL[g])) == PT[g];
            if (full) begin
               if (mcnt[g] < 3) mcnt[g]++;
               if (!ov) hlen[g] = 0;
            end
         end
         x.pd[g]  = full;
         x.ml[g]  = 4'(prefix_len(g));
         x.cnt[g] = 2'(mcnt[g]);
      end
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic seq(input logic [15:0] bits, input int n, input logic ov);
      for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], ov);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         for (int g = 0; g < N; g++) begin
            checks++;
            if (pd[g] !== x.pd[g]) begin
               errors++;
               $display("FAIL pd[%0d] t=%0t got %b expected %b", g, $time, pd[g], x.pd[g]);
            end
            checks++;
            if (ml[g] !== x.ml[g]) begin
               errors++;
               $display("FAIL match_len[%0d] t=%0t got %0d expected %0d", g, $time, ml[g], x.ml[g]);
            end
`ifdef MATCH_COUNT_EN
            checks++;
            if (cnt[g] !== x.cnt[g]) begin
               errors++;
               $display("FAIL match_cnt[%0d] t=%0t got %0d expected %0d", g, $time, cnt[g], x.cnt[g]);
            end
`endif
         end
      end
   end

   initial begin
      logic ov;
      for (int g = 0; g < N; g++) begin
         hist[g] = '0;
         hlen[g] = 0;
         mcnt[g] = 0;
      end
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      seq(16'b00101, 5, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seq(16'b000101, 6, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seq(16'b1011011, 7, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      seq(16'b1011011, 7, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seq(16'b001, 3, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i[0], 1'b1);
      seq(16'b01, 2, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seq(16'b0010, 4, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      seq(16'b00101, 5, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      seq(16'b000000, 6, 1'b1);
      seq(16'b000000, 6, 1'b0);
      ov = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) ov = !ov;
         step($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, ($urandom % 2) == 1, ov);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
